// File: rtl/pulse_generator_pkg.sv
// Shared constants for the programmable periodic strobe generator.
package pulse_generator_pkg;

    localparam int PG_DEFAULT_N = 8;

endpackage : pulse_generator_pkg

// File: rtl/pulse_generator.sv
// Programmable periodic strobe: one-cycle pulse on out every max(ticks,1) enabled cycles.
// Optional build macro PULSE_GENERATOR_PHASE_OUT_EN adds a phase output mirroring the counter.
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int N = PG_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] ticks,
    output logic         out
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
    ,
    output logic [N-1:0] phase
`endif
);

    logic [N-1:0] counter_r;
    logic         out_r;
    logic [N-1:0] counter_nxt_s;
    logic         out_nxt_s;
    logic [N-1:0] period_m1_s;
    logic         wrap_s;

    // Terminal count: ticks of 0 behaves as a period of 1, so the limit is 0.
    always_comb begin
        period_m1_s = {N{1'b0}};
        if (ticks == {N{1'b0}}) begin
            period_m1_s = {N{1'b0}};
        end else begin
            period_m1_s = ticks - N'(1);
        end
        wrap_s = (counter_r >= period_m1_s);
    end

    // Next counter/pulse value; >= compare lets a shortened period wrap at once.
    always_comb begin
        counter_nxt_s = counter_r;
        out_nxt_s     = 1'b0;
        if (ena) begin
            if (wrap_s) begin
                counter_nxt_s = {N{1'b0}};
                out_nxt_s     = 1'b1;
            end else begin
                counter_nxt_s = counter_r + N'(1);
                out_nxt_s     = 1'b0;
            end
        end else begin
            counter_nxt_s = counter_r;
            out_nxt_s     = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_r <= {N{1'b0}};
            out_r     <= 1'b0;
        end else begin
            counter_r <= counter_nxt_s;
            out_r     <= out_nxt_s;
        end
    end

    assign out = out_r;

`ifdef PULSE_GENERATOR_PHASE_OUT_EN
    assign phase = counter_r;
`endif

endmodule : pulse_generator

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator (N=7, 120-cycle period) with a behavioural reference model.
module tb_pulse_generator;

    localparam int N = 7;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [N-1:0] ticks;
    logic         out;
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
    logic [N-1:0] phase;
`endif

    int vectors;
    int miscompares;
    bit started;

    // reference model: enabled edges elapsed since the last pulse or reset
    int elapsed;
    bit exp_out;
    int last_phase;

    pulse_generator #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .ticks (ticks),
        .out   (out)
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
        ,
        .phase (phase)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a pulse follows the edge that completes a period of max(ticks,1) enabled edges.
    always @(posedge clk) begin
        int p;
        p = (int'(ticks) == 0) ? 1 : int'(ticks);
        if (rst) begin
            elapsed = 0;
            exp_out = 1'b0;
        end else if (ena) begin
            if (elapsed + 1 >= p) begin
                elapsed = 0;
                exp_out = 1'b1;
            end else begin
                elapsed = elapsed + 1;
                exp_out = 1'b0;
            end
        end else begin
            exp_out = 1'b0;
        end
        started = 1'b1;
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (out !== exp_out) begin
                miscompares++;
                $display("FAIL out_model t=%0t out=%b required=%b", $time, out, exp_out);
            end
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
            vectors++;
            if (int'(phase) != elapsed) begin
                miscompares++;
                $display("FAIL phase_model t=%0t phase=%0d required=%0d", $time, phase, elapsed);
            end
`endif
        end
    end

    task automatic check(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic count_high(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out) highs++;
        end
    endtask

    // Returns the number of edges until out is seen high, or -1 if the bound expires.
    task automatic wait_pulse(input int max_edges, output int edges);
        bit found;
        found = 1'b0;
        edges = -1;
        for (int i = 1; i <= max_edges && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out) begin
                edges = i;
                found = 1'b1;
            end else begin
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
                last_phase = int'(phase);
`endif
            end
        end
    endtask

    initial begin
        int highs;
        int edges;
        int first_pos;
        int prev_pos;
        int bad_gap;

        vectors     = 0;
        miscompares = 0;
        started     = 1'b0;
        elapsed     = 0;
        exp_out     = 1'b0;
        last_phase  = 0;
        rst         = 1'b1;
        ena         = 1'b1;
        ticks       = 7'd120;

        // reset held for two edges with ena high
        step(2);
        check("reset_out", int'(out), 0);

        // 1200 cycles at a 120-cycle period
        rst = 1'b0;
        highs = 0; first_pos = -1; prev_pos = -1; bad_gap = 0;
        for (int i = 1; i <= 1200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out) begin
                highs++;
                if (first_pos < 0) first_pos = i;
                if (prev_pos >= 0 && i - prev_pos != 120) bad_gap++;
                prev_pos = i;
            end
        end
        check("run_pulse_count", highs, 10);
        check("run_first_pulse", first_pos, 120);
        check("run_bad_gaps", bad_gap, 0);

        // pause mid-period for 240 cycles, then resume
        step(50);
        ena = 1'b0;
        count_high(240, highs);
        check("paused_highs", highs, 0);
        ena = 1'b1;
        wait_pulse(200, edges);
        check("resume_remaining", edges, 70);
        wait_pulse(200, edges);
        check("resume_period", edges, 120);

        // P == 1 through ticks=1 and ticks=0
        ticks = 7'd1;
        count_high(20, highs);
        check("ticks1_high", highs, 20);
        ticks = 7'd0;
        count_high(20, highs);
        check("ticks0_high", highs, 20);

        // shorten period below the running count
        ticks = 7'd120;
        step(100);
        check("pre_shorten_out", int'(out), 0);
        ticks = 7'd50;
        wait_pulse(5, edges);
        check("shorten_wrap", edges, 1);
        wait_pulse(100, edges);
        check("shorten_period", edges, 50);

        // reset mid-period
        ticks = 7'd120;
        step(30);
        rst = 1'b1;
        step(1);
        check("midreset_out", int'(out), 0);
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
        check("midreset_phase", int'(phase), 0);
`endif
        rst = 1'b0;
        wait_pulse(200, edges);
        check("post_reset_first", edges, 120);
`ifdef PULSE_GENERATOR_PHASE_OUT_EN
        check("phase_before_pulse", last_phase, 119);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 3) == 0) ticks = 7'($urandom_range(0, 4));
                else ticks = 7'($urandom_range(0, 127));
            end
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pulse_generator
